// File: rtl/ahb_pkg.sv
// Shared AHB encodings, the slave state enum and size/alignment helpers
// used by the SRAM slave and its bench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } slave_state_t;

    function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            HSIZE_HALF: bad = lsb[0];
            HSIZE_WORD: bad = (lsb != 2'b00);
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Little-endian lane enables for a legal, aligned access.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lsb;
            HSIZE_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word-organised storage split into four byte lanes: one byte-enabled
// synchronous write port and one asynchronous read port. Contents are not reset.
module sram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[waddr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states on OKAY transfers, two-cycle
// ERROR response for illegal size, misalignment or out-of-range addresses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);

    slave_state_t  state_reg;
    logic [3:0]    wait_cnt_reg;
    logic          hreadyout_reg;
    logic          hresp_reg;
    logic          dp_valid_reg;
    logic          dp_write_reg;
    logic [AW-1:0] dp_index_reg;
    logic [3:0]    dp_be_reg;

    logic          capture;
    logic          cap_error;
    logic          mem_we;
    logic [31:0]   rd_word;

    // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{hburst, htrans[0]};

    assign capture   = hsel & hready & htrans[1];
    assign cap_error = (hsize > HSIZE_WORD)
                     || size_misaligned(hsize, haddr[1:0])
                     || ({2'b00, haddr[31:2]} >= DEPTH_W);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 4'd0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= HRESP_OKAY;
            dp_valid_reg  <= 1'b0;
            dp_write_reg  <= 1'b0;
            dp_index_reg  <= '0;
            dp_be_reg     <= 4'b0000;
        end else begin
            case (state_reg)
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    if (wait_cnt_reg <= 4'd1) begin
                        state_reg     <= IDLE;
                        hreadyout_reg <= 1'b1;
                    end
                end
                ERR1: begin
                    state_reg     <= ERR2;
                    hreadyout_reg <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both end a data phase and evaluate a new address phase.
                    state_reg     <= IDLE;
                    wait_cnt_reg  <= 4'd0;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= HRESP_OKAY;
                    dp_valid_reg  <= 1'b0;
                    if (capture) begin
                        dp_write_reg <= hwrite;
                        dp_index_reg <= haddr[AW+1:2];
                        dp_be_reg    <= byte_enables(hsize, haddr[1:0]);
                        if (cap_error) begin
                            state_reg     <= ERR1;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= HRESP_ERROR;
                        end else begin
                            dp_valid_reg <= 1'b1;
                            if (WS != 4'd0) begin
                                state_reg     <= WAIT;
                                wait_cnt_reg  <= WS;
                                hreadyout_reg <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Writes land on the edge that closes the data phase, so a following read sees them.
    assign mem_we = dp_valid_reg & dp_write_reg & hreadyout_reg;

    sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (hclk),
        .we    (mem_we),
        .be    (dp_be_reg),
        .waddr (dp_index_reg),
        .wdata (hwdata),
        .raddr (dp_index_reg),
        .rdata (rd_word)
    );

    assign hreadyout = hreadyout_reg;
    assign hresp     = hresp_reg;
    assign hrdata    = (dp_valid_reg & ~dp_write_reg & hreadyout_reg) ? rd_word : 32'h0;

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit memory words (a power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the wait cycles inserted per OKAY data phase (0..15).
REQ-003 SHALL have port hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port hresetn, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port hsel, input, 1, the slave select from the decoder.
REQ-006 SHALL have port haddr, input, 32, the byte address.
REQ-007 SHALL have port hwrite, input, 1, where 1 means write and 0 means read.
REQ-008 SHALL have port hsize, input, 3, the transfer size (0 byte, 1 halfword, 2 word).
REQ-009 SHALL have port hburst, input, 3, the burst type; it is ignored and every beat is treated as a single transfer.
REQ-010 SHALL have port htrans, input, 2, the transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-011 SHALL have port hwdata, input, 32, the write data, valid in the data phase.
REQ-012 SHALL have port hready, input, 1, the bus-level ready; the previous transfer completes when it is high.
REQ-013 SHALL have port hreadyout, output, 1, the slave ready.
REQ-014 SHALL have port hresp, output, 1, the response (0 OKAY, 1 ERROR).
REQ-015 SHALL have port hrdata, output, 32, the read data.

Function
REQ-016 SHALL capture haddr, hwrite and hsize as an address phase only when hsel=1, hready=1 and htrans[1]=1.
REQ-017 SHALL treat IDLE and BUSY, or hsel=0, with hready=1 as no transfer; the next cycle returns OKAY with zero wait.
REQ-018 SHALL flag a captured transfer as an error on any of:
- hsize>2;
- address misaligned for its size;
- word index haddr[31:2] >= DEPTH.
REQ-019 SHALL use FSM states IDLE, WAIT, ERR1, ERR2:
- IDLE goes to WAIT on a valid capture when WAIT_STATES>0;
- IDLE goes to ERR1 on an error capture;
- IDLE stays in IDLE otherwise.
REQ-020 SHALL hold hreadyout=0 and hresp=0 in WAIT for exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then complete with hreadyout=1.
REQ-021 SHALL drive hreadyout=0 and hresp=1 in ERR1, then hreadyout=1 and hresp=1 in ERR2, and leave ERR2 with a fresh address-phase evaluation.
REQ-022 SHALL commit a write at the clock edge ending its data phase (hreadyout=1), using hwdata and little-endian byte enables derived from the captured haddr[1:0] and hsize.
REQ-023 SHALL perform no memory write for an errored transfer.
REQ-024 SHALL drive hrdata = mem[captured index] (the full word) while a read data phase has hreadyout=1, and 0 at all other times.
REQ-025 SHALL return the new data when a read immediately follows a write to the same word, because the write commits at the edge that starts the read data phase.
REQ-026 SHALL accept back-to-back transfers: the completing data phase overlaps the next address phase, with no idle cycle when WAIT_STATES=0.
REQ-027 SHALL treat a captured index as wrapping modulo DEPTH only after the range check, so no out-of-range write is ever possible.

Reset
REQ-028 SHALL, while hresetn=0, force state IDLE, wait counter 0, hreadyout=1, hresp=0, hrdata=0, and clear captured phase registers.
REQ-029 SHALL abandon any transfer in progress when reset asserts, with no memory write.
REQ-030 SHALL leave memory contents unreset.

Structure
REQ-031 SHALL take the following from shared package ahb_pkg:
- htrans encodings;
- hsize encodings;
- hresp encodings;
- the slave state enum.
REQ-032 SHALL place storage in sub-module sram_array, with one write port with 4 byte enables and one asynchronous read port, sized by DEPTH.

Verification
REQ-033 SHALL cover this case with WAIT_STATES=1: NONSEQ write of 0xDEADBEEF to 0x10, then read of 0x10 -> write hreadyout low for 1 cycle; read returns 0xDEADBEEF, hresp=0.
REQ-034 SHALL cover this case: byte write of 0xAB to 0x13 over a word holding 0x11223344 -> readback of 0xAB223344.
REQ-035 SHALL cover this case with DEPTH=256: word read of 0x400 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); memory unchanged.
REQ-036 SHALL cover this case: halfword access at 0x01 and hsize=3 access -> both take the two-cycle ERROR response with no write.
REQ-037 SHALL cover this case with WAIT_STATES=0: back-to-back write 0x5 to 0x20 then read 0x20 -> read returns 0x00000005 the next cycle, hreadyout stays 1.
REQ-038 SHALL cover this case: hresetn pulsed low in WAIT of a write of 0x1 to 0x30 -> outputs at reset values immediately; later read of 0x30 returns the pre-reset content.
